// File: rtl/alsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alsu_pkg
// Brief    : Shared opcode encodings and LED blinker state encoding for the ALSU.
// Revision : 1.0
// ============================================================================
package alsu_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MULT  = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  typedef enum logic [0:0] {
    ST_OK    = 1'b0,
    ST_BLINK = 1'b1
  } led_state_e;

endpackage
`default_nettype wire

// File: rtl/alsu_led_blinker.sv
`default_nettype none
// ============================================================================
// Module   : alsu_led_blinker
// Brief    : Error indicator; blinks all LEDs while the last result was invalid.
// Revision : 1.0
// ============================================================================
module alsu_led_blinker
  import alsu_pkg::*;
#(
  parameter int LED_W     = 16,
  parameter int BLINK_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             err_evt,
  input  logic             ok_evt,
  output logic [LED_W-1:0] leds
);

  localparam int               CNT_W      = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BLINK_CYC - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  led_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [LED_W-1:0] r_leds;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_OK;
      r_cnt   <= '0;
      r_leds  <= '0;
    end else begin
      case (r_state)
        ST_OK: begin
          if (err_evt) begin
            r_state <= ST_BLINK;
            r_cnt   <= '0;
            r_leds  <= '1;
          end
        end
        ST_BLINK: begin
          // A repeated error keeps the blink phase running rather than restarting it
          if (ok_evt) begin
            r_state <= ST_OK;
            r_cnt   <= '0;
            r_leds  <= '0;
          end else if (r_cnt == C_CNT_LAST) begin
            r_cnt  <= '0;
            r_leds <= ~r_leds;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        default: r_state <= ST_OK;
      endcase
    end
  end

  assign leds = r_leds;

endmodule
`default_nettype wire

// File: rtl/alsu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alsu_pipe
// Brief    : Two-stage handshaked logic/arith/shift unit with LED error blinker.
// Revision : 1.0
// ============================================================================
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int    WIDTH          = 4,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16,
  parameter int    BLINK_CYC      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         opcode,
  input  logic               cin,
  input  logic               serial_in,
  input  logic               direction,
  input  logic               red_op_A,
  input  logic               red_op_B,
  input  logic               bypass_A,
  input  logic               bypass_B,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  output logic               err,
  output logic [LED_W-1:0]   leds
);

  localparam int OUT_W      = 2 * WIDTH;
  localparam bit C_PRI_A    = (INPUT_PRIORITY == "A");
  localparam bit C_FULL_ADD = (FULL_ADDER == "ON");

  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_op;
  logic             r_cin, r_sin, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b, r_v1;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid, r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cin   <= 1'b0;
      r_sin   <= 1'b0;
      r_dir   <= 1'b0;
      r_red_a <= 1'b0;
      r_red_b <= 1'b0;
      r_byp_a <= 1'b0;
      r_byp_b <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      r_a     <= A;
      r_b     <= B;
      r_op    <= opcode;
      r_cin   <= cin;
      r_sin   <= serial_in;
      r_dir   <= direction;
      r_red_a <= red_op_A;
      r_red_b <= red_op_B;
      r_byp_a <= bypass_A;
      r_byp_b <= bypass_B;
      r_v1    <= in_valid;
    end
  end

  logic [WIDTH-1:0] w_byp_x, w_red_x;
  logic [WIDTH:0]   w_sum;
  logic [OUT_W-1:0] w_prod, w_res;
  logic             w_red, w_inv, w_err;

  // Operand selection when both flags of a pair are set follows INPUT_PRIORITY
  assign w_byp_x = (r_byp_a && (!r_byp_b || C_PRI_A)) ? r_a : r_b;
  assign w_red_x = (r_red_a && (!r_red_b || C_PRI_A)) ? r_a : r_b;
  assign w_red   = r_red_a | r_red_b;
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin & C_FULL_ADD};
  assign w_prod  = OUT_W'(r_a) * OUT_W'(r_b);
  assign w_inv   = (r_op > OP_ROT) ||
                   (w_red && (r_op inside {OP_ADD, OP_MULT, OP_SHIFT, OP_ROT}));

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    if (r_byp_a || r_byp_b) begin
      w_res = OUT_W'(w_byp_x);
    end else if (w_inv) begin
      w_err = 1'b1;
    end else begin
      case (r_op)
        OP_AND:   w_res = w_red ? OUT_W'(&w_red_x) : OUT_W'(r_a & r_b);
        OP_XOR:   w_res = w_red ? OUT_W'(^w_red_x) : OUT_W'(r_a ^ r_b);
        OP_ADD:   w_res = OUT_W'(w_sum);
        OP_MULT:  w_res = w_prod;
        // Shift/rotate act on the result register, so chained ops need no bubble
        OP_SHIFT: w_res = r_dir ? {r_out[OUT_W-2:0], r_sin} : {r_sin, r_out[OUT_W-1:1]};
        OP_ROT:   w_res = r_dir ? {r_out[OUT_W-2:0], r_out[OUT_W-1]}
                                : {r_out[0], r_out[OUT_W-1:1]};
        default:  w_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_out <= w_res;
        r_err <= w_err;
      end
    end
  end

  logic w_err_evt, w_ok_evt;
  assign w_err_evt = r_v1 & w_err;
  assign w_ok_evt  = r_v1 & ~w_err;

  alsu_led_blinker #(
    .LED_W     (LED_W),
    .BLINK_CYC (BLINK_CYC)
  ) u_blinker (
    .clk     (clk),
    .rst     (rst),
    .err_evt (w_err_evt),
    .ok_evt  (w_ok_evt),
    .leds    (leds)
  );

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alsu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alsu_pipe
// Brief    : Scoreboard bench for alsu_pipe (WIDTH=4, full adder, BLINK_CYC=4).
// Revision : 1.0
// ============================================================================
module tb_alsu_pipe;

  localparam int WIDTH     = 4;
  localparam int LED_W     = 16;
  localparam int BLINK_CYC = 4;

  logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic [2:0] opcode = '0;
  logic       cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
  logic       red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
  logic [7:0] out;
  logic       out_valid, err;
  logic [15:0] leds;

  alsu_pipe #(
    .WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
    .LED_W(LED_W), .BLINK_CYC(BLINK_CYC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out), .out_valid(out_valid), .err(err), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] res; logic e; } exp_t;
  exp_t q[$];
  int   n_tests = 0, n_fail = 0;
  int   m_out = 0;
  bit   m_blink = 1'b0;
  int   m_k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: last result kept as an integer; shifts/rotates via multiply/divide mod 256
  function automatic exp_t ref_model(input int op, input int a, input int b, input int c,
                                     input int s, input int d, input bit ra, input bit rb,
                                     input bit ba, input bit bb);
    exp_t e;
    int   x, r;
    e.e = 1'b0;
    x   = ra ? a : b;
    r   = 0;
    if (ba || bb) r = ba ? a : b;
    else if (op >= 6 || ((ra || rb) && op >= 2)) e.e = 1'b1;
    else begin
      case (op)
        0: r = (ra || rb) ? int'(x == 15) : (a & b);
        1: r = (ra || rb) ? ($countones(x) % 2) : (a ^ b);
        2: r = a + b + c;
        3: r = a * b;
        4: r = d ? (m_out * 2 + s) % 256 : m_out / 2 + s * 128;
        default: r = d ? (m_out * 2 + m_out / 128) % 256 : m_out / 2 + (m_out % 2) * 128;
      endcase
    end
    m_out = r;
    e.res = r[7:0];
    return e;
  endfunction

  task automatic issue(input int op, input int a, input int b, input bit c, input bit s,
                       input bit d, input bit ra, input bit rb, input bit ba, input bit bb);
    opcode = op[2:0]; A = a[3:0]; B = b[3:0]; cin = c; serial_in = s; direction = d;
    red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb; in_valid = 1'b1;
    q.push_back(ref_model(op, a, b, c, s, d, ra, rb, ba, bb));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      A = 4'($urandom); B = 4'($urandom); opcode = 3'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops expectations on out_valid and tracks the LED blink pattern
  initial begin
    exp_t e;
    bit   ev, ev_err;
    int   want;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_blink = 1'b0;
        m_k     = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_leds", leds, 0);
      end else begin
        ev = 1'b0; ev_err = 1'b0;
        if (out_valid) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            e = q.pop_front();
            check("out", out, e.res);
            check("err", err, e.e);
            ev = 1'b1; ev_err = e.e;
          end
        end
        if (m_blink) begin
          if (ev && !ev_err) m_blink = 1'b0;
          else m_k++;
        end else if (ev && ev_err) begin
          m_blink = 1'b1;
          m_k     = 0;
        end
        want = (m_blink && ((m_k / BLINK_CYC) % 2 == 0)) ? 32'hFFFF : 0;
        check("leds", leds, want);
      end
    end
  end

  initial begin
    int wait_cyc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 0);
    check("reset_err", err, 0);
    rst = 1'b1;
    idle(2);

    // Bypass wins over an invalid opcode; result two edges after driving
    issue(7, 9, 3, 0, 0, 0, 0, 0, 1, 1);
    check("latency_early", out_valid, 0);
    @(posedge clk); #1;
    check("latency_valid", out_valid, 1);
    check("bypass_out", out, 8'h09);
    idle(1);

    issue(2, 15, 15, 1, 0, 0, 0, 0, 0, 0);   // 0x1F
    issue(3, 15, 15, 0, 0, 0, 0, 0, 0, 0);   // 0xE1
    issue(0, 15, 0, 0, 0, 0, 1, 1, 0, 0);    // 0x01
    issue(1, 5, 3, 0, 0, 0, 0, 0, 0, 0);     // 0x06
    issue(0, 3, 0, 0, 0, 0, 0, 0, 1, 0);     // 0x03
    issue(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);     // 0x81
    issue(5, 0, 0, 0, 0, 1, 0, 0, 0, 0);     // 0x03
    issue(5, 0, 0, 0, 0, 1, 0, 0, 0, 0);     // 0x06
    issue(4, 0, 0, 0, 1, 0, 0, 0, 0, 0);     // 0x83
    idle(3);

    issue(6, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    idle(13);
    issue(2, 1, 2, 0, 0, 0, 1, 0, 0, 0);     // still invalid: blinking continues
    idle(5);
    issue(0, 12, 10, 0, 0, 0, 0, 0, 0, 0);   // valid: leds clear
    idle(3);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset in the middle of a stream
    issue(3, 7, 9, 0, 0, 0, 0, 0, 0, 0);
    opcode = 3'd2; A = 4'd5; B = 4'd6; in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midrst_out", out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_leds", leds, 0);
    q.delete();
    m_out = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_edge1", out_valid, 0);
    @(posedge clk); #1;
    check("post_rst_edge2", out_valid, 0);
    issue(4, 0, 0, 0, 1, 1, 0, 0, 0, 0);     // shift from cleared register: 0x01
    idle(1);

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("drain", q.size(), 0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
